// File: rtl/multiword_add_seq.sv
// rtl/multiword_add_seq.sv - W-bit add/subtract serialised over WORDS passes of an external N-bit adder
// Operands are held as WORDS x N chunk arrays so the active chunk is selected by idx directly.
module multiword_add_seq #(
  parameter int N = 32,
  parameter int WORDS = 4,
  localparam int W = N * WORDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout,
  output logic         out_ovf,
  output logic         busy,
  output logic [N-1:0] add_a,
  output logic [N-1:0] add_b,
  output logic         add_cin,
  input  logic [N-1:0] add_s,
  input  logic         add_cout
);

  localparam int IW = $clog2(WORDS);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state;
  logic [IW-1:0]           idx;
  logic                    carry_reg;
  logic [WORDS-1:0][N-1:0] a_reg;
  logic [WORDS-1:0][N-1:0] b_reg;
  logic [WORDS-1:0][N-1:0] sum_reg;

  // Subtract is A + ~B + 1: B is inverted at capture and the +1 rides in as the first carry-in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= in_a;
            b_reg     <= in_sub ? ~in_b : in_b;
            carry_reg <= in_sub;
            idx       <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          sum_reg[idx] <= add_s;
          carry_reg    <= add_cout;
          if (idx == LAST) begin
            out_cout <= add_cout;
            out_ovf  <= (a_reg[WORDS-1][N-1] == b_reg[WORDS-1][N-1]) &&
                        (add_s[N-1] != a_reg[WORDS-1][N-1]);
            idx      <= '0;
            state    <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign add_a   = (state == RUN) ? a_reg[idx] : '0;
  assign add_b   = (state == RUN) ? b_reg[idx] : '0;
  assign add_cin = (state == RUN) ? carry_reg : 1'b0;

  assign out_sum   = sum_reg;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: doc/multiword_add_seq.md
MULTIWORD_ADD_SEQ -- requirements
Module: multiword_add_seq

Interface
REQ-001 The block SHALL have the following parameters:
- N, 32, chunk width in bits; one external adder pass covers one chunk.
- WORDS, 4, chunks per operand; legal range is 2 or more.
- W, N*WORDS, operand and result width; derived, not overridable.
REQ-002 The block SHALL have the following ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- in_sub  in  1  1 selects A-B; 0 selects A+B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  W  result.
- out_cout  out  1  final carry; for subtract, 1 means no borrow (A>=B unsigned).
- out_ovf  out  1  two's-complement signed overflow.
- busy  out  1  high in RUN or DONE.
- add_a  out  N  chunk of A driven to the external combinational adder.
- add_b  out  N  chunk of B (inverted for subtract) driven to the adder.
- add_cin  out  1  carry-in driven to the adder.
- add_s  in  N  adder sum, same-cycle combinational return.
- add_cout  in  1  adder carry-out, same-cycle combinational return.

Function
REQ-003 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-004 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-005 Acceptance SHALL occur on an edge with in_valid=1 in IDLE.
- Capture in_a into a_reg.
- Capture in_sub ? ~in_b : in_b into b_reg.
- Set carry_reg to in_sub and idx to 0.
- Go to RUN.
REQ-006 In RUN, the chunk outputs SHALL be combinational from registers:
- add_a = a_reg[idx*N +: N].
- add_b = b_reg[idx*N +: N].
- add_cin = carry_reg.
REQ-007 On every RUN edge, the block SHALL write add_s into sum chunk idx, load carry_reg from add_cout, and increment idx.
REQ-008 On the RUN edge with idx = WORDS-1, the block SHALL do the following:
- Load out_cout from add_cout.
- Load out_ovf = (a_reg[W-1] == b_reg[W-1]) && (add_s[N-1] != a_reg[W-1]).
- Go to DONE.
REQ-009 out_valid SHALL rise exactly WORDS cycles after the accepting edge, with chunks processed LSB first.
REQ-010 In DONE, out_sum, out_cout and out_ovf SHALL stay stable until the edge with out_ready=1; that edge SHALL return the FSM to IDLE.
REQ-011 A new request SHALL NOT be accepted on the same edge as an output handshake; minimum request-to-request spacing is WORDS+2 cycles.
REQ-012 Changes on in_a, in_b or in_sub after acceptance SHALL NOT affect the result.
REQ-013 Outside RUN, add_a, add_b and add_cin SHALL be driven to 0.
REQ-014 out_sum SHALL hold its last value in IDLE, and the sum register SHALL only be written in RUN.
REQ-015 Arithmetic SHALL be modulo 2^W, with no saturation.
REQ-016 idx SHALL be $clog2(WORDS) bits wide and SHALL never exceed WORDS-1.

Reset
REQ-017 While rst_n=0, all of the following SHALL hold immediately, independent of clk:
- FSM in IDLE.
- idx=0, carry_reg=0.
- a_reg, b_reg and the sum register all 0.
- out_valid=0, out_cout=0, out_ovf=0, busy=0.
- in_ready=1 once rst_n=1.
REQ-018 Reset asserted in RUN or DONE SHALL discard the operation in flight, with no partial result visible afterwards.
REQ-019 The first acceptance after reset release SHALL be possible on the first rising edge with rst_n=1.

Verification (N=32, WORDS=4; the bench models the adder as {add_cout,add_s} = add_a+add_b+add_cin)
REQ-020 Add wrap: A=all ones, B=1, sub=0 -> out_sum=0, out_cout=1, out_ovf=0; out_valid high exactly 4 cycles after the accept edge.
REQ-021 Carry chain: A=0x00000001_FFFFFFFF_FFFFFFFF_FFFFFFFF, B=1 -> add_cin sequence 0,1,1,1 across RUN cycles; out_sum=0x00000002_00000000_00000000_00000000; out_cout=0.
REQ-022 Subtract with borrow: A=5, B=7, sub=1 -> out_sum=0xFFFF...FFFE, out_cout=0, out_ovf=0; first-cycle add_cin=1; add_b chunk 0 = 0xFFFFFFF8.
REQ-023 Signed overflow: A=0x7FFF...FF, B=1, sub=0 -> out_sum=0x8000...00, out_ovf=1, out_cout=0.
REQ-024 Backpressure: out_ready=0 for 10 cycles in DONE with in_valid held high -> outputs stable, in_ready=0, no acceptance; after the out_ready=1 edge, the next request is accepted one cycle later.
REQ-025 Reset mid-operation: rst_n pulsed low after 2 RUN edges -> out_valid=0, busy=0 and out_sum=0 without a clock edge; the next request completes with the correct result.
